lc3b_control: RTL and testbench

- Multicycle control FSM for the LC-3b datapath.
- Sequences fetch, decode and execute using the IR decode fields (opcode, imm, bit11) and the branch-enable flag.
- Drives every datapath load enable, mux select and ALU op, and handshakes with memory via mem_read/mem_write/mem_resp.

---
 rtl/lc3b_control.sv | 215 +++++++++++++++++++++
 tb/tb_lc3b_control.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_control.sv
// Multicycle fetch/decode/execute control FSM for the LC-3b datapath.
// Optional memory-wait abort enabled by defining CTRL_MEM_TIMEOUT_EN.
package lc3b_types;
    typedef enum logic [3:0] {
        op_br   = 4'b0000, op_add = 4'b0001, op_ldb = 4'b0010, op_stb  = 4'b0011,
        op_jsr  = 4'b0100, op_and = 4'b0101, op_ldr = 4'b0110, op_str  = 4'b0111,
        op_rti  = 4'b1000, op_not = 4'b1001, op_ldi = 4'b1010, op_sti  = 4'b1011,
        op_jmp  = 4'b1100, op_shf = 4'b1101, op_lea = 4'b1110, op_trap = 4'b1111
    } lc3b_opcode;

    typedef enum logic [1:0] {alu_add, alu_and, alu_not, alu_pass} lc3b_aluop;
endpackage

module lc3b_control
    import lc3b_types::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  lc3b_opcode opcode,
    input  logic       imm,
    input  logic       bit11,
    input  logic       branch_enable,
    input  logic       mem_resp,
    output logic       load_pc,
    output logic       load_ir,
    output logic       load_regfile,
    output logic       load_mar,
    output logic       load_mdr,
    output logic       load_cc,
    output logic [1:0] pcmux_sel,
    output logic [1:0] alumux_sel,
    output logic [1:0] regfilemux_sel,
    output logic       marmux_sel,
    output logic       mdrmux_sel,
    output lc3b_aluop  aluop,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] mem_byte_enable,
    output logic       mem_timeout
);

    typedef enum logic [4:0] {
        S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE, S_ADD, S_AND, S_NOT, S_BR,
        S_BR_TAKEN, S_CALC_ADDR, S_LDR1, S_LDR2, S_STR1, S_STR2, S_JMP, S_JSR, S_LEA
    } state_t;

    state_t state_q, state_d;
    logic   wait_st;
    logic   timeout_hit;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("lc3b_control: TIMEOUT_CYCLES must be >= 2");
    end

    assign wait_st = (state_q == S_FETCH2) || (state_q == S_LDR1) || (state_q == S_STR2);

`ifdef CTRL_MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_timeout_q, mem_timeout_d;

    // No two wait states are adjacent, so clearing outside waits covers every entry.
    always_comb begin
        cnt_d         = '0;
        timeout_hit   = 1'b0;
        if (wait_st && !mem_resp) begin
            cnt_d       = cnt_q + CW'(1);
            timeout_hit = (cnt_q == LIMIT);
        end
        mem_timeout_d = timeout_hit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign mem_timeout = mem_timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign mem_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_FETCH1;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        load_pc         = 1'b0;
        load_ir         = 1'b0;
        load_regfile    = 1'b0;
        load_mar        = 1'b0;
        load_mdr        = 1'b0;
        load_cc         = 1'b0;
        pcmux_sel       = 2'b00;
        alumux_sel      = 2'b00;
        regfilemux_sel  = 2'b00;
        marmux_sel      = 1'b0;
        mdrmux_sel      = 1'b0;
        aluop           = alu_add;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 2'b11;

        unique case (state_q)
            S_FETCH1: begin
                load_mar = 1'b1;
                load_pc  = 1'b1;
                state_d  = S_FETCH2;
            end
            S_FETCH2: begin
                mem_read   = 1'b1;
                mdrmux_sel = 1'b1;
                load_mdr   = 1'b1;
                if (mem_resp) state_d = S_FETCH3;
            end
            S_FETCH3: begin
                load_ir = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                unique case (opcode)
                    op_add:         state_d = S_ADD;
                    op_and:         state_d = S_AND;
                    op_not:         state_d = S_NOT;
                    op_br:          state_d = S_BR;
                    op_ldr, op_str: state_d = S_CALC_ADDR;
                    op_jmp:         state_d = S_JMP;
                    op_jsr:         state_d = S_JSR;
                    op_lea:         state_d = S_LEA;
                    default:        state_d = S_FETCH1;
                endcase
            end
            S_ADD, S_AND: begin
                load_regfile = 1'b1;
                load_cc      = 1'b1;
                alumux_sel   = imm ? 2'b01 : 2'b00;
                aluop        = (state_q == S_AND) ? alu_and : alu_add;
                state_d      = S_FETCH1;
            end
            S_NOT: begin
                load_regfile = 1'b1;
                load_cc      = 1'b1;
                aluop        = alu_not;
                state_d      = S_FETCH1;
            end
            S_BR: state_d = branch_enable ? S_BR_TAKEN : S_FETCH1;
            S_BR_TAKEN: begin
                load_pc   = 1'b1;
                pcmux_sel = 2'b01;
                state_d   = S_FETCH1;
            end
            S_CALC_ADDR: begin
                alumux_sel = 2'b10;
                load_mar   = 1'b1;
                marmux_sel = 1'b1;
                state_d    = (opcode == op_str) ? S_STR1 : S_LDR1;
            end
            S_LDR1: begin
                mem_read   = 1'b1;
                mdrmux_sel = 1'b1;
                load_mdr   = 1'b1;
                if (mem_resp) state_d = S_LDR2;
            end
            S_LDR2: begin
                load_regfile   = 1'b1;
                regfilemux_sel = 2'b01;
                load_cc        = 1'b1;
                state_d        = S_FETCH1;
            end
            S_STR1: begin
                load_mdr = 1'b1;
                aluop    = alu_pass;
                state_d  = S_STR2;
            end
            S_STR2: begin
                mem_write = 1'b1;
                if (mem_resp) state_d = S_FETCH1;
            end
            S_JMP: begin
                load_pc   = 1'b1;
                pcmux_sel = 2'b10;
                state_d   = S_FETCH1;
            end
            S_JSR: begin
                load_regfile   = 1'b1;
                regfilemux_sel = 2'b10;
                load_pc        = 1'b1;
                pcmux_sel      = bit11 ? 2'b11 : 2'b10;
                state_d        = S_FETCH1;
            end
            S_LEA: begin
                load_regfile   = 1'b1;
                regfilemux_sel = 2'b11;
                load_cc        = 1'b1;
                state_d        = S_FETCH1;
            end
            default: state_d = S_FETCH1;
        endcase

        if (timeout_hit) state_d = S_FETCH1;
    end

endmodule

// File: tb/tb_lc3b_control.sv
// Randomized instruction-stream bench: expected per-cycle control words come from
// an instruction-level phase model; cycles that must not sample an input get noise.
module tb_lc3b_control;
    import lc3b_types::*;

    logic       clk = 1'b0;
    logic       rst_n;
    lc3b_opcode opcode;
    logic       imm, bit11, branch_enable, mem_resp;
    logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
    logic [1:0] pcmux_sel, alumux_sel, regfilemux_sel;
    logic       marmux_sel, mdrmux_sel;
    lc3b_aluop  aluop;
    logic       mem_read, mem_write, mem_timeout;
    logic [1:0] mem_byte_enable;

    lc3b_control #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .imm(imm), .bit11(bit11),
        .branch_enable(branch_enable), .mem_resp(mem_resp),
        .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
        .load_mar(load_mar), .load_mdr(load_mdr), .load_cc(load_cc),
        .pcmux_sel(pcmux_sel), .alumux_sel(alumux_sel), .regfilemux_sel(regfilemux_sel),
        .marmux_sel(marmux_sel), .mdrmux_sel(mdrmux_sel), .aluop(aluop),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ld_pc, ld_ir, ld_rf, ld_mar, ld_mdr, ld_cc;
        logic [1:0] pcmux, alumux, rfmux;
        logic       marmux, mdrmux;
        logic [1:0] aluop;
        logic       rd, wr;
        logic [1:0] be;
        logic       tmo;
    } ctl_t;

    typedef struct {
        string      name;
        ctl_t       c;
        logic       resp;
        lc3b_opcode op;
        logic       imm, b11, be;
    } cyc_t;

    ctl_t obs;
    assign obs = {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
                  pcmux_sel, alumux_sel, regfilemux_sel, marmux_sel, mdrmux_sel,
                  aluop, mem_read, mem_write, mem_byte_enable, mem_timeout};

    cyc_t       q[$];
    int         total = 0;
    int         bad   = 0;
    lc3b_opcode cur_op;
    logic       cur_imm, cur_b11, cur_be;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic ctl_t idle();
        ctl_t c = '0;
        c.be = 2'b11;
        return c;
    endfunction

    // rel=1: this cycle's decision depends on the instruction fields; otherwise drive noise.
    // rsp<0: memory response is irrelevant in this cycle, so randomize it.
    task automatic put(input string name, input ctl_t c, input bit rel, input int rsp);
        cyc_t e;
        e.name = name;
        e.c    = c;
        e.resp = (rsp < 0) ? 1'($urandom_range(1, 0)) : 1'(rsp);
        if (rel) begin
            e.op = cur_op; e.imm = cur_imm; e.b11 = cur_b11; e.be = cur_be;
        end else begin
            e.op  = lc3b_opcode'($urandom_range(15, 0));
            e.imm = 1'($urandom_range(1, 0));
            e.b11 = 1'($urandom_range(1, 0));
            e.be  = 1'($urandom_range(1, 0));
        end
        q.push_back(e);
    endtask

    function automatic ctl_t f1_word();
        ctl_t c = idle();
        c.ld_mar = 1'b1; c.ld_pc = 1'b1;
        return c;
    endfunction

    function automatic ctl_t rd_word();
        ctl_t c = idle();
        c.rd = 1'b1; c.mdrmux = 1'b1; c.ld_mdr = 1'b1;
        return c;
    endfunction

    task automatic mem_phase(input string name, input ctl_t c, input int w);
        for (int i = 0; i < w; i++) put(name, c, 1'b0, 0);
        put(name, c, 1'b0, 1);
    endtask

    // Fetch3, decode and execute phases; cut leaves the store waiting with no response.
    task automatic tail(input int w2, input bit cut);
        ctl_t c;
        c = idle(); c.ld_ir = 1'b1;
        put("fetch_ir", c, 1'b0, -1);
        put("decode", idle(), 1'b1, -1);
        c = idle();
        case (cur_op)
            op_add, op_and: begin
                c.ld_rf = 1'b1; c.ld_cc = 1'b1;
                c.alumux = cur_imm ? 2'b01 : 2'b00;
                c.aluop  = (cur_op == op_and) ? alu_and : alu_add;
                put("alu_exec", c, 1'b1, -1);
            end
            op_not: begin
                c.ld_rf = 1'b1; c.ld_cc = 1'b1; c.aluop = alu_not;
                put("not_exec", c, 1'b1, -1);
            end
            op_br: begin
                put("br_eval", c, 1'b1, -1);
                if (cur_be) begin
                    c.ld_pc = 1'b1; c.pcmux = 2'b01;
                    put("br_taken", c, 1'b0, -1);
                end
            end
            op_ldr, op_str: begin
                c.alumux = 2'b10; c.ld_mar = 1'b1; c.marmux = 1'b1;
                put("calc_addr", c, 1'b1, -1);
                if (cur_op == op_ldr) begin
                    mem_phase("ldr_wait", rd_word(), w2);
                    c = idle(); c.ld_rf = 1'b1; c.rfmux = 2'b01; c.ld_cc = 1'b1;
                    put("ldr_wb", c, 1'b0, -1);
                end else begin
                    c = idle(); c.ld_mdr = 1'b1; c.aluop = alu_pass;
                    put("str_mdr", c, 1'b0, -1);
                    c = idle(); c.wr = 1'b1;
                    if (cut) begin
                        put("str_wait", c, 1'b0, 0);
                        put("str_wait", c, 1'b0, 0);
                    end else begin
                        mem_phase("str_wait", c, w2);
                    end
                end
            end
            op_jmp: begin
                c.ld_pc = 1'b1; c.pcmux = 2'b10;
                put("jmp_exec", c, 1'b1, -1);
            end
            op_jsr: begin
                c.ld_rf = 1'b1; c.rfmux = 2'b10; c.ld_pc = 1'b1;
                c.pcmux = cur_b11 ? 2'b11 : 2'b10;
                put("jsr_exec", c, 1'b1, -1);
            end
            op_lea: begin
                c.ld_rf = 1'b1; c.rfmux = 2'b11; c.ld_cc = 1'b1;
                put("lea_exec", c, 1'b1, -1);
            end
            default: ;
        endcase
    endtask

    task automatic instr(input lc3b_opcode op, input logic i5, input logic b11,
                         input logic be, input int w1, input int w2);
        cur_op = op; cur_imm = i5; cur_b11 = b11; cur_be = be;
        put("fetch_mar", f1_word(), 1'b0, -1);
        mem_phase("fetch_wait", rd_word(), w1);
        tail(w2, 1'b0);
    endtask

    // Entered at a negedge; each queue entry is one clock cycle.
    task automatic run_q();
        cyc_t e;
        while (q.size() != 0) begin
            e = q.pop_front();
            opcode = e.op; imm = e.imm; bit11 = e.b11; branch_enable = e.be;
            mem_resp = e.resp;
            #1;
            chk(e.name, 32'(obs), 32'(e.c));
            @(negedge clk);
        end
    endtask

    task automatic check_reset_word(input string tag);
        chk(tag, 32'(obs), 32'(f1_word()));
        chk({tag, "_tmo"}, 32'(mem_timeout), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; opcode = op_br; imm = 1'b0; bit11 = 1'b0;
        branch_enable = 1'b0; mem_resp = 1'b0;
        @(negedge clk); @(negedge clk);
        check_reset_word("reset_init");
        rst_n = 1'b1;

        instr(op_add, 1'b1, 1'b0, 1'b0, 0, 0);
        instr(op_br,  1'b0, 1'b0, 1'b0, 0, 0);
        instr(op_br,  1'b0, 1'b0, 1'b1, 0, 0);
        instr(op_ldr, 1'b0, 1'b0, 1'b0, 3, 3);
        instr(op_jsr, 1'b0, 1'b1, 1'b0, 0, 0);
        instr(op_jsr, 1'b0, 1'b0, 1'b0, 0, 0);
        instr(op_trap, 1'b0, 1'b0, 1'b0, 1, 0);
        run_q();

        // Reset arriving while a store is waiting on memory.
        cur_op = op_str; cur_imm = 1'b0; cur_b11 = 1'b0; cur_be = 1'b0;
        put("fetch_mar", f1_word(), 1'b0, -1);
        mem_phase("fetch_wait", rd_word(), 0);
        tail(0, 1'b1);
        run_q();
        rst_n = 1'b0; mem_resp = 1'b0;
        @(negedge clk);
        check_reset_word("reset_str2_a");
        mem_resp = 1'b1;
        @(negedge clk);
        check_reset_word("reset_str2_b");
        rst_n = 1'b1;

        for (int n = 0; n < 200; n++)
            instr(lc3b_opcode'($urandom_range(15, 0)), 1'($urandom_range(1, 0)),
                  1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                  int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
        run_q();

`ifdef CTRL_MEM_TIMEOUT_EN
        begin
            ctl_t c;
            cur_op = op_add; cur_imm = 1'b0; cur_b11 = 1'b0; cur_be = 1'b0;
            put("tmo_fetch_mar", f1_word(), 1'b0, -1);
            for (int i = 0; i < 4; i++) put("tmo_wait", rd_word(), 1'b0, 0);
            c = f1_word(); c.tmo = 1'b1;
            put("tmo_pulse", c, 1'b0, -1);
            mem_phase("tmo_refetch", rd_word(), 0);
            tail(0, 1'b0);
            instr(op_add, 1'b1, 1'b0, 1'b0, 3, 0);
            instr(op_ldr, 1'b0, 1'b0, 1'b0, 0, 3);
            run_q();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
